// File: rtl/mem_responder_if.sv
// mem_responder_if: cache-controller-to-memory request/acknowledge bus.
// mem_err is only present when MEM_ADDR_CHECK_EN is defined.
interface mem_responder_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef MEM_ADDR_CHECK_EN
    logic        mem_err;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ready, mem_ack, mem_rdata, mem_err);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ready, mem_ack, mem_rdata, mem_err);
`else
    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ready, mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ready, mem_ack, mem_rdata);
`endif
endinterface

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory answering cache refills and write-backs.
// Define MEM_ADDR_CHECK_EN to flag out-of-range addresses on mem_err instead of wrapping.
module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    localparam logic [3:0] LOAD = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic we_q, err_q, oor;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [2**DEPTH_LOG2];
`ifdef MEM_ADDR_CHECK_EN
    assign oor = |(bus.mem_addr >> DEPTH_LOG2);
    assign bus.mem_err = state == ACK && err_q;
`else
    assign oor = 1'b0;
`endif
    assign bus.mem_ready = state == IDLE;
    assign bus.mem_ack   = state == ACK;
    assign bus.mem_rdata = (state == ACK && !we_q && !err_q) ? mem[idx_q] : 32'h0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (bus.mem_req) begin
                state_nxt = LATENCY == 1 ? ACK : WAIT;
                cnt_nxt   = LOAD;
            end
            WAIT: if (cnt == 4'd0) state_nxt = ACK;
                  else cnt_nxt = cnt - 4'd1;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
        end else if (state == IDLE && bus.mem_req) begin
            we_q    <= bus.mem_we;
            err_q   <= oor;
            idx_q   <= bus.mem_addr[DEPTH_LOG2-1:0];
            wdata_q <= bus.mem_wdata;
        end
    end
    // Async reset drops state out of ACK immediately, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (state == ACK && we_q && !err_q) mem[idx_q] <= wdata_q;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: vector table plus scoreboard for mem_responder (LATENCY 3 and 1 instances).
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if b ();
    mem_responder_if b1 ();
    mem_responder #(.DEPTH_LOG2(10), .LATENCY(3)) dut  (.clk(clk), .rst(rst), .bus(b));
    mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (b.mem_ack) begin
                if (sb.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
                else begin
                    mon_e = sb.pop_front();
                    chk("rdata", b.mem_rdata, mon_e.rdata);
`ifdef MEM_ADDR_CHECK_EN
                    chk("err", {31'd0, b.mem_err}, {31'd0, mon_e.err});
`endif
                end
            end else begin
                chk("rdata_idle", b.mem_rdata, 32'h0);
            end
        end
    end

    task automatic txn(input logic we, input logic [29:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp, input logic err);
        int k;
        for (k = 0; k < 40 && !b.mem_ready; k++) @(negedge clk);
        b.mem_req = 1'b1; b.mem_we = we; b.mem_addr = addr; b.mem_wdata = wd;
        sb.push_back('{exp, err});
        @(posedge clk);
        #1 b.mem_req = 1'b0; b.mem_we = ~we; b.mem_addr = 30'($urandom); b.mem_wdata = $urandom;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (b.mem_ack) break;
            chk("ready_low_wait", {31'd0, b.mem_ready}, 32'd0);
        end
        chk("ack_latency", k, 3);
        chk("ready_low_ack", {31'd0, b.mem_ready}, 32'd0);
        @(negedge clk);
        chk("ack_one_cycle", {31'd0, b.mem_ack}, 32'd0);
        chk("ready_after", {31'd0, b.mem_ready}, 32'd1);
    endtask

    initial begin
        int base, k;
        vecs.push_back('{1'b1, 30'h0,   32'hA0A0A0A0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 30'h5,   32'hDEADBEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 30'h5,   32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 30'h1,   32'h11111111, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 30'h2,   32'h22222222, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 30'h3,   32'h33333333, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 30'h9,   32'hAAAA0009, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 30'h1,   32'h0,        32'h11111111, 1'b0});
        vecs.push_back('{1'b1, 30'h3FF, 32'hFFFF03FF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 30'h3FF, 32'h0,        32'hFFFF03FF, 1'b0});
        vecs.push_back('{1'b1, 30'h5,   32'hCAFEF00D, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 30'h5,   32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b0, 30'h0,   32'h0,        32'hA0A0A0A0, 1'b0});
`ifdef MEM_ADDR_CHECK_EN
        vecs.push_back('{1'b1, 30'h400, 32'h5555AAAA, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 30'h0,   32'h0,        32'hA0A0A0A0, 1'b0});
        vecs.push_back('{1'b0, 30'h405, 32'h0,        32'h0, 1'b1});
`else
        vecs.push_back('{1'b0, 30'h405, 32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b1, 30'h400, 32'h5555AAAA, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 30'h0,   32'h0,        32'h5555AAAA, 1'b0});
`endif
        b.mem_req = 1'b0; b.mem_we = 1'b0; b.mem_addr = '0; b.mem_wdata = '0;
        b1.mem_req = 1'b0; b1.mem_we = 1'b0; b1.mem_addr = '0; b1.mem_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, b.mem_ready}, 32'd1);
        chk("rst_ack", {31'd0, b.mem_ack}, 32'd0);
        chk("rst_rdata", b.mem_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);

        // back-to-back reads with mem_req held high: acks at cycles 3, 7, 11
        b.mem_req = 1'b1; b.mem_we = 1'b0; b.mem_addr = 30'h1;
        sb.push_back('{32'h11111111, 1'b0});
        sb.push_back('{32'h22222222, 1'b0});
        sb.push_back('{32'h33333333, 1'b0});
        base = cyc;
        for (int i = 0; i < 3; i++) begin
            for (k = 0; k < 20; k++) begin
                @(negedge clk);
                if (b.mem_ack) break;
            end
            chk("b2b_ack_cycle", cyc - base, 3 + 4 * i);
            if (i < 2) b.mem_addr = 30'(i + 2);
        end
        b.mem_req = 1'b0;
        @(negedge clk);

        // toggling mem_req during WAIT must not create a second transfer
        b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_addr = 30'd20; b.mem_wdata = 32'h20202020;
        sb.push_back('{32'h0, 1'b0});
        @(posedge clk);
        #1 b.mem_req = 1'b0;
        @(negedge clk) b.mem_req = 1'b1;
        @(negedge clk) b.mem_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("no_extra_ack", sb.size(), 0);

        // reset during WAIT aborts the write to addr 9
        b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_addr = 30'd9; b.mem_wdata = 32'h12345678;
        @(posedge clk);
        #1 b.mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, b.mem_ready}, 32'd1);
        chk("abort_ack", {31'd0, b.mem_ack}, 32'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {31'd0, b.mem_ready}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_ack", {31'd0, b.mem_ack}, 32'd0);
        end
        txn(1'b0, 30'd9, 32'h0, 32'hAAAA0009, 1'b0);

        // LATENCY=1 instance: ack in cycle 1, ready again in cycle 2
        b1.mem_req = 1'b1; b1.mem_we = 1'b1; b1.mem_addr = 30'd7; b1.mem_wdata = 32'h77777777;
        @(posedge clk);
        #1 b1.mem_req = 1'b0;
        @(negedge clk);
        chk("l1_wr_ack", {31'd0, b1.mem_ack}, 32'd1);
        chk("l1_wr_ready", {31'd0, b1.mem_ready}, 32'd0);
        @(negedge clk);
        chk("l1_wr_ack_end", {31'd0, b1.mem_ack}, 32'd0);
        chk("l1_wr_ready_back", {31'd0, b1.mem_ready}, 32'd1);
        b1.mem_req = 1'b1; b1.mem_we = 1'b0; b1.mem_addr = 30'd7;
        @(posedge clk);
        #1 b1.mem_req = 1'b0;
        @(negedge clk);
        chk("l1_rd_ack", {31'd0, b1.mem_ack}, 32'd1);
        chk("l1_rd_data", b1.mem_rdata, 32'h77777777);
        @(negedge clk);
        chk("l1_rd_data_after", b1.mem_rdata, 32'h0);
        chk("l1_rd_ready_back", {31'd0, b1.mem_ready}, 32'd1);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
